// File: rtl/femto_clk_pkg.sv
// rtl/femto_clk_pkg.sv - shared types, default timing and counter sizing for the femto clock/reset controller
package femto_clk_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT   = 4096;
  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_MAX_RETRIES    = 7;
  localparam int DEF_SYNC_STAGES    = 2;

  // Counter only has to reach max-1, so clog2(max) bits suffice; never narrower than 1.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/femto_sync_bit.sv
// rtl/femto_sync_bit.sv - multi-flop single-bit synchronizer with synchronous active-low reset
module femto_sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/femto_clk_rst_ctrl.sv
// rtl/femto_clk_rst_ctrl.sv - PLL reset sequencing, lock supervision and core reset release
module femto_clk_rst_ctrl
  import femto_clk_pkg::*;
#(
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       core_resetn,
  output logic [2:0] state,
  output logic [3:0] retry_count,
  output logic [7:0] lock_loss_count,
  output logic       fail
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          locked_s;
  logic          cnt_clr, retry_inc, retry_clr, loss_inc;

  femto_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_lock_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (pll_locked),
    .q      (locked_s)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= ST_PLL_RESET;
      cnt_q           <= '0;
      retry_count     <= '0;
      lock_loss_count <= '0;
      pll_rst         <= 1'b1;
      core_resetn     <= 1'b0;
      fail            <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cnt_clr) begin
        cnt_q <= '0;
      end else if (state_q != ST_FAIL) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (retry_clr) begin
        retry_count <= '0;
      end else if (retry_inc) begin
        retry_count <= retry_count + 4'd1;
      end
      if (loss_inc) begin
        lock_loss_count <= lock_loss_count + 8'd1;
      end
      pll_rst     <= (state_d == ST_PLL_RESET);
      core_resetn <= (state_d == ST_RUN);
      fail        <= (state_d == ST_FAIL);
    end
  end

  // A soft request restarts from any state; lock beats timeout in WAIT_LOCK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PLL_RESET: begin
        if (soft_reset_req)      state_d = ST_PLL_RESET;
        else if (cnt_q == PR_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (soft_reset_req)        state_d = ST_PLL_RESET;
        else if (locked_s)         state_d = ST_STABLE;
        else if (cnt_q == LT_LAST) state_d = (retry_count == RETRY_MAX) ? ST_FAIL : ST_PLL_RESET;
      end
      ST_STABLE: begin
        if (soft_reset_req)        state_d = ST_PLL_RESET;
        else if (!locked_s)        state_d = ST_WAIT_LOCK;
        else if (cnt_q == ST_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!locked_s || soft_reset_req) state_d = ST_PLL_RESET;
      end
      ST_FAIL: begin
        if (soft_reset_req) state_d = ST_PLL_RESET;
      end
      default: state_d = ST_PLL_RESET;
    endcase
  end

  always_comb begin
    cnt_clr   = (state_d != state_q) || soft_reset_req;
    retry_inc = (state_q == ST_WAIT_LOCK) && (state_d == ST_PLL_RESET) && !soft_reset_req;
    retry_clr = ((state_q == ST_STABLE) && (state_d == ST_RUN)) ||
                ((state_q == ST_FAIL) && (state_d == ST_PLL_RESET));
    loss_inc  = (state_q == ST_RUN) && !locked_s && (lock_loss_count != 8'hff);
  end

  assign state = state_q;

endmodule

// File: tb/tb_femto_clk_rst_ctrl.sv
// tb/tb_femto_clk_rst_ctrl.sv - directed self-checking bench for femto_clk_rst_ctrl
module tb_femto_clk_rst_ctrl;

  localparam int P = 4;
  localparam int L = 32;
  localparam int S = 16;
  localparam int R = 2;
  localparam int N = 2;
  localparam int BOUND = 200;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pll_locked;
  logic       soft_reset_req;
  logic       pll_rst;
  logic       core_resetn;
  logic [2:0] state;
  logic [3:0] retry_count;
  logic [7:0] lock_loss_count;
  logic       fail;

  int checks = 0;
  int errors = 0;
  int n;
  int tmo;

  femto_clk_rst_ctrl #(
    .PLL_RST_CYCLES (P),
    .LOCK_TIMEOUT   (L),
    .STABLE_CYCLES  (S),
    .MAX_RETRIES    (R),
    .SYNC_STAGES    (N)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .pll_locked      (pll_locked),
    .soft_reset_req  (soft_reset_req),
    .pll_rst         (pll_rst),
    .core_resetn     (core_resetn),
    .state           (state),
    .retry_count     (retry_count),
    .lock_loss_count (lock_loss_count),
    .fail            (fail)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic measure_rst(input logic v, output int cnt);
    cnt = 0;
    while (pll_rst === v && cnt < BOUND) begin
      cnt++;
      tick();
    end
  endtask

  task automatic wait_core(input logic v, output int cnt);
    cnt = 0;
    while (core_resetn !== v && cnt < BOUND) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_state(input logic [2:0] s, output int cnt);
    cnt = 0;
    while (state !== s && cnt < BOUND) begin
      tick();
      cnt++;
    end
  endtask

  task automatic pulse_soft();
    soft_reset_req = 1'b1;
    tick();
    soft_reset_req = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    pll_locked = 1'b0;
    soft_reset_req = 1'b0;
    tmo = 0;
    repeat (3) tick();

    check("rst_state", state, 0);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_core", core_resetn, 0);
    check("rst_retry", retry_count, 0);
    check("rst_loss", lock_loss_count, 0);
    check("rst_fail", fail, 0);

    // timeout/retry with lock held low
    resetn = 1'b1;
    measure_rst(1'b1, n); check("tmo_w1", n, P);
    check("tmo_r0", retry_count, 0);
    measure_rst(1'b0, n); check("tmo_g1", n, L);
    check("tmo_r1", retry_count, 1);
    measure_rst(1'b1, n); check("tmo_w2", n, P);
    measure_rst(1'b0, n); check("tmo_g2", n, L);
    check("tmo_r2", retry_count, 2);
    measure_rst(1'b1, n); check("tmo_w3", n, P);
    n = 0;
    while (!fail && n < BOUND) begin tick(); n++; end
    check("tmo_g3", n, L);
    check("fail_state", state, 4);
    check("fail_flag", fail, 1);
    check("fail_core", core_resetn, 0);
    check("fail_pll_rst", pll_rst, 0);
    repeat (5) tick();
    check("fail_hold", state, 4);
    pulse_soft();
    check("fsoft_state", state, 0);
    check("fsoft_retry", retry_count, 0);
    check("fsoft_fail", fail, 0);
    check("fsoft_pll_rst", pll_rst, 1);

    // lock arrives exactly on the timeout cycle
    measure_rst(1'b1, n); check("lot_w1", n, P);
    measure_rst(1'b0, n); check("lot_g1", n, L);
    measure_rst(1'b1, n); check("lot_w2", n, P);
    repeat (L - 3) tick();
    pll_locked = 1'b1;
    tick(); tick();
    check("lot_pre", state, 1);
    tick();
    check("lot_state", state, 2);
    check("lot_retry", retry_count, 1);
    wait_core(1'b1, n); check("lot_stable", n, S);
    check("run_state", state, 3);
    check("run_retry_clr", retry_count, 0);

    // lock loss in RUN
    pll_locked = 1'b0;
    wait_core(1'b0, n); check("loss_lat", n, N + 1);
    check("loss_cnt1", lock_loss_count, 1);
    check("loss_state", state, 0);
    tick(); tick();
    pll_locked = 1'b1;
    wait_core(1'b1, n); check("loss_recover", core_resetn, 1);

    // loss and soft request seen together
    pll_locked = 1'b0;
    tick(); tick();
    check("sim_pre", state, 3);
    pulse_soft();
    check("sim_state", state, 0);
    check("sim_cnt", lock_loss_count, 2);
    pll_locked = 1'b1;
    wait_core(1'b1, n); check("sim_recover", core_resetn, 1);

    // soft request alone in RUN
    pulse_soft();
    check("soft_state", state, 0);
    check("soft_cnt", lock_loss_count, 2);
    check("soft_core", core_resetn, 0);

    // one-cycle glitch at stable count 8
    wait_state(3'd2, n); check("gl_reach", state, 2);
    repeat (8) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick(); tick();
    check("gl_wait", state, 1);
    check("gl_core", core_resetn, 0);
    check("gl_retry", retry_count, 0);
    tick();
    check("gl_stable", state, 2);
    wait_core(1'b1, n); check("gl_full", n, S);

    // reset mid-STABLE, then nominal bring-up
    pulse_soft();
    wait_state(3'd2, n); check("rs_reach", state, 2);
    repeat (3) tick();
    resetn = 1'b0;
    pll_locked = 1'b0;
    tick();
    check("rs_state", state, 0);
    check("rs_pll_rst", pll_rst, 1);
    check("rs_core", core_resetn, 0);
    check("rs_loss", lock_loss_count, 0);
    resetn = 1'b1;
    measure_rst(1'b1, n); check("nom_w", n, P);
    repeat (10 - P) tick();
    pll_locked = 1'b1;
    wait_core(1'b1, n); check("nom_lat", n, N + S + 1);
    check("nom_state", state, 3);

    // reset in RUN
    resetn = 1'b0;
    tick();
    check("rr_core", core_resetn, 0);
    check("rr_state", state, 0);
    check("rr_pll_rst", pll_rst, 1);
    resetn = 1'b1;
    measure_rst(1'b1, n); check("rr_w", n, P);
    wait_core(1'b1, n); check("rr_recover", core_resetn, 1);

    // saturation of lock_loss_count
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b0;
      wait_core(1'b0, n);
      if (n >= BOUND) tmo++;
      tick(); tick();
      pll_locked = 1'b1;
      wait_core(1'b1, n);
      if (n >= BOUND) tmo++;
      if (i == 253) check("sat_254", lock_loss_count, 254);
    end
    check("sat_255", lock_loss_count, 255);
    check("sat_timeouts", tmo, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
